// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg: shared constants for the writeback commit trace.
// Trace entry layout, MSB to LSB: {reg, data, pc, seq[, cycle]}.
// Defining WB_TRACE_TIMESTAMP_EN appends a 32-bit capture-cycle field.
package wb_trace_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int TR_REG_W  = 5;
  localparam int TR_DATA_W = 32;
  localparam int TR_PC_W   = 12;
  localparam int TR_SEQ_W  = 16;
`ifdef WB_TRACE_TIMESTAMP_EN
  localparam int TR_CYC_W  = 32;
`else
  localparam int TR_CYC_W  = 0;
`endif

  // Bit offsets for the default field widths
  localparam int TR_CYC_LSB  = 0;
  localparam int TR_SEQ_LSB  = TR_CYC_LSB + TR_CYC_W;
  localparam int TR_PC_LSB   = TR_SEQ_LSB + TR_SEQ_W;
  localparam int TR_DATA_LSB = TR_PC_LSB + TR_PC_W;
  localparam int TR_REG_LSB  = TR_DATA_LSB + TR_DATA_W;

  localparam int TRACE_ENTRY_W = TR_REG_LSB + TR_REG_W;

  // Entry width for non-default PC/seq widths
  function automatic int trace_entry_w(input int pc_w, input int seq_w);
    return TR_REG_W + TR_DATA_W + pc_w + seq_w + TR_CYC_W;
  endfunction

endpackage

// File: rtl/wb_trace_mem.sv
// wb_trace_mem: DEPTH x W trace storage, one synchronous write port,
// one asynchronous read port.
module wb_trace_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int W      = 65
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Write the captured entry on the clock edge
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/wb_commit_trace.sv
// wb_commit_trace: captures qualifying register writebacks into a
// show-ahead trace FIFO drained over valid/ready. Overflow is sticky and
// dropped commits are counted. Optional macro WB_TRACE_TIMESTAMP_EN adds
// a free-running cycle stamp per entry on out_cycle.
module wb_commit_trace
  import wb_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int PC_W   = 12,
  parameter int SEQ_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [4:0]        wb_reg,
  input  logic [31:0]       wb_data,
  input  logic [PC_W-1:0]   wb_pc,
  input  logic              freeze,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_reg,
  output logic [31:0]       out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [SEQ_W-1:0]  out_seq,
`ifdef WB_TRACE_TIMESTAMP_EN
  output logic [31:0]       out_cycle,
`endif
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  // Field offsets for this instance's widths
  localparam int L_SEQ   = TR_CYC_W;
  localparam int L_PC    = L_SEQ + SEQ_W;
  localparam int L_DATA  = L_PC + PC_W;
  localparam int L_REG   = L_DATA + TR_DATA_W;
  localparam int ENTRY_W = trace_entry_w(PC_W, SEQ_W);

  logic [ADDR_W:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       drop_q, drop_d;
  logic [ENTRY_W-1:0] last_q, last_d;
  logic [ENTRY_W-1:0] wr_entry, head, shown;
  logic              qual, push, pop, drop;
`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0]       cyc_q, cyc_d;
`endif

  // Occupancy derived from the extra pointer bit
  assign count     = wptr_q - rptr_q;
  assign full      = (count == (ADDR_W+1)'(DEPTH));
  assign out_valid = (count != '0);

  // Commit qualification and FIFO handshake
  always_comb begin
    qual = wb_we && (wb_reg != REG_ZERO) && !freeze;
    pop  = out_valid && out_ready;
    push = qual && (!full || pop);
    drop = qual && full && !pop;
  end

  // Pack the committing instruction into a trace entry
  always_comb begin
    wr_entry = '0;
    wr_entry[L_REG  +: TR_REG_W]  = wb_reg;
    wr_entry[L_DATA +: TR_DATA_W] = wb_data;
    wr_entry[L_PC   +: PC_W]      = wb_pc;
    wr_entry[L_SEQ  +: SEQ_W]     = seq_q;
`ifdef WB_TRACE_TIMESTAMP_EN
    wr_entry[0 +: 32]             = cyc_q;
`endif
  end

  wb_trace_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (ENTRY_W)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wptr_q[ADDR_W-1:0]),
    .wdata (wr_entry),
    .raddr (rptr_q[ADDR_W-1:0]),
    .rdata (head)
  );

  // Next-state for pointers, seq, overflow tracking and held output
  always_comb begin
    wptr_d = wptr_q + (ADDR_W+1)'(push);
    rptr_d = rptr_q + (ADDR_W+1)'(pop);
    seq_d  = qual ? seq_q + 1'b1 : seq_q;
    ovf_d  = ovf_q | drop;
    drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    // Track the head so outputs hold once the FIFO drains
    last_d = out_valid ? head : last_q;
`ifdef WB_TRACE_TIMESTAMP_EN
    cyc_d  = cyc_q + 32'd1;
`endif
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      seq_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
      last_q <= '0;
`ifdef WB_TRACE_TIMESTAMP_EN
      cyc_q  <= '0;
`endif
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      seq_q  <= seq_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
      last_q <= last_d;
`ifdef WB_TRACE_TIMESTAMP_EN
      cyc_q  <= cyc_d;
`endif
    end
  end

  // Show-ahead head while valid, otherwise the last head seen
  assign shown      = out_valid ? head : last_q;
  assign out_reg    = shown[L_REG  +: TR_REG_W];
  assign out_data   = shown[L_DATA +: TR_DATA_W];
  assign out_pc     = shown[L_PC   +: PC_W];
  assign out_seq    = shown[L_SEQ  +: SEQ_W];
`ifdef WB_TRACE_TIMESTAMP_EN
  assign out_cycle  = shown[0 +: 32];
`endif
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_wb_commit_trace.sv
// Directed bench for wb_commit_trace (default parameters).
module tb_wb_commit_trace;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [11:0] wb_pc;
  logic        freeze;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_reg;
  logic [31:0] out_data;
  logic [11:0] out_pc;
  logic [15:0] out_seq;
`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0] out_cycle;
`endif
  logic [4:0]  count;
  logic        full;
  logic        overflow;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;

  wb_commit_trace dut (
    .clock      (clock),
    .reset      (reset),
    .wb_we      (wb_we),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .wb_pc      (wb_pc),
    .freeze     (freeze),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_reg    (out_reg),
    .out_data   (out_data),
    .out_pc     (out_pc),
    .out_seq    (out_seq),
`ifdef WB_TRACE_TIMESTAMP_EN
    .out_cycle  (out_cycle),
`endif
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic commit(input logic [4:0] r, input logic [31:0] d, input logic [11:0] pc);
    wb_we = 1'b1; wb_reg = r; wb_data = d; wb_pc = pc;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; wb_we = 1'b0; wb_reg = '0; wb_data = '0; wb_pc = '0;
    freeze = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_reg", 32'(out_reg), 0);
    chk("rst_data", out_data, 0);
    chk("rst_seq", 32'(out_seq), 0);
    reset = 1'b1;
    tick();

    // 1: single capture, then pop and hold last value
    commit(5'd3, 32'h0000_0005, 12'h010);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_reg", 32'(out_reg), 3);
    chk("t1_data", out_data, 32'h5);
    chk("t1_pc", 32'(out_pc), 32'h010);
    chk("t1_seq", 32'(out_seq), 0);
    chk("t1_count", 32'(count), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t1_empty", 32'(out_valid), 0);
    chk("t1_hold_reg", 32'(out_reg), 3);
    chk("t1_hold_data", out_data, 32'h5);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t1_ready_empty", 32'(count), 0);

    // 2: writes to $0 are not traced
    pulse_reset();
    commit(5'd0, 32'hDEAD_BEEF, 12'h020);
    chk("t2_zero_count", 32'(count), 0);
    commit(5'd7, 32'h0000_0077, 12'h024);
    chk("t2_count", 32'(count), 1);
    chk("t2_reg", 32'(out_reg), 7);
    chk("t2_seq", 32'(out_seq), 0);

    // 3: overflow with 18 commits, ordered drain, seq gap
    pulse_reset();
    for (int i = 0; i < 18; i++) commit(5'(1 + i % 31), 32'(i), 12'(i));
    chk("t3_count", 32'(count), 16);
    chk("t3_full", 32'(full), 1);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_drop", 32'(drop_count), 2);
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain_seq", 32'(out_seq), 32'(i));
      chk("t3_drain_data", out_data, 32'(i));
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    chk("t3_drained", 32'(count), 0);
    commit(5'd5, 32'h55, 12'h055);
    chk("t3_next_seq", 32'(out_seq), 18);
    chk("t3_ovf_sticky", 32'(overflow), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 4: full with simultaneous push and pop (seq now 19)
    for (int i = 0; i < 16; i++) commit(5'd9, 32'(100 + i), 12'h100);
    chk("t4_full", 32'(full), 1);
    wb_we = 1'b1; wb_reg = 5'd9; wb_data = 32'h999; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t4_pop_seq", 32'(out_seq), 32'(19 + k));
      tick();
      chk("t4_count", 32'(count), 16);
      chk("t4_drop", 32'(drop_count), 2);
    end
    wb_we = 1'b0; out_ready = 1'b0;
    chk("t4_head_seq", 32'(out_seq), 24);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    out_ready = 1'b0;
    chk("t4_drained", 32'(count), 0);

    // 5: freeze ignores commits without consuming seq (seq now 40)
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) commit(5'd2, 32'h22, 12'h200);
    chk("t5_frozen", 32'(count), 0);
    freeze = 1'b0;
    commit(5'd4, 32'h44, 12'h204);
    chk("t5_count", 32'(count), 1);
    chk("t5_reg", 32'(out_reg), 4);
    chk("t5_seq", 32'(out_seq), 40);
    freeze = 1'b1; out_ready = 1'b1; tick(); out_ready = 1'b0; freeze = 1'b0;
    chk("t5_pop_frozen", 32'(count), 0);

    // 6: reset mid-drain discards everything
    for (int i = 0; i < 5; i++) commit(5'd6, 32'(i), 12'h300);
    chk("t6_count5", 32'(count), 5);
    reset = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6_count", 32'(count), 0);
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_drop", 32'(drop_count), 0);
    chk("t6_ovf", 32'(overflow), 0);
    chk("t6_out_seq", 32'(out_seq), 0);
    reset = 1'b1;
    commit(5'd6, 32'h66, 12'h306);
    chk("t6_seq", 32'(out_seq), 0);
    chk("t6_reg", 32'(out_reg), 6);
`ifdef WB_TRACE_TIMESTAMP_EN
    chk("t6_cycle", out_cycle, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
